// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one instruction memory port between the CPU fetch
// stage and the loader/debug port. Each grant gets exactly one response, one cycle later.
module imem_arbiter #(
  parameter int MEM_SIZE = 512,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [31:0]       f_rdata_o,
  output logic              f_err_o,
  input  logic              l_req_i,
  input  logic              l_we_i,
  input  logic [ADDR_W-1:0] l_addr_i,
  input  logic [31:0]       l_wdata_i,
  output logic              l_gnt_o,
  output logic              l_rvalid_o,
  output logic [31:0]       l_rdata_o,
  output logic              l_err_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  // state      | meaning
  // RSP_IDLE   | no response due this cycle
  // RSP_ACTIVE | response for last cycle's grant is being returned
  typedef enum logic {RSP_IDLE, RSP_ACTIVE} rsp_state_t;
  typedef enum logic {OWN_FETCH, OWN_LOADER} owner_t;
  typedef enum logic [1:0] {KIND_READ, KIND_WRITE, KIND_ERR} kind_t;

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_SIZE - 4);

  rsp_state_t        r_state, w_state_nxt;
  owner_t            r_last_owner, w_last_owner_nxt;
  owner_t            r_rsp_owner, w_rsp_owner_nxt;
  kind_t             r_rsp_kind, w_rsp_kind_nxt;

  logic              w_f_win, w_l_win, w_gnt, w_legal, w_sel_we, w_rsp_live;
  logic [ADDR_W-1:0] w_sel_addr;

  // Fetch wins unless the loader is asking and fetch owned the previous grant.
  assign w_f_win    = !rst && f_req_i && (!l_req_i || (r_last_owner == OWN_LOADER));
  assign w_l_win    = !rst && l_req_i && !w_f_win;
  assign w_gnt      = w_f_win || w_l_win;
  assign w_sel_addr = w_l_win ? l_addr_i : f_addr_i;
  assign w_sel_we   = w_l_win && l_we_i;
  assign w_legal    = (w_sel_addr[1:0] == 2'b00) && (w_sel_addr <= MAX_ADDR);

  assign f_gnt_o     = w_f_win;
  assign l_gnt_o     = w_l_win;
  assign mem_en_o    = w_gnt && w_legal;
  assign mem_we_o    = mem_en_o && w_sel_we;
  assign mem_addr_o  = w_gnt ? w_sel_addr : '0;
  assign mem_wdata_o = mem_we_o ? l_wdata_i : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RSP_IDLE;
      r_last_owner <= OWN_LOADER;
      r_rsp_owner  <= OWN_FETCH;
      r_rsp_kind   <= KIND_READ;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_rsp_owner  <= w_rsp_owner_nxt;
      r_rsp_kind   <= w_rsp_kind_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = RSP_IDLE;
    w_last_owner_nxt = r_last_owner;
    w_rsp_owner_nxt  = r_rsp_owner;
    w_rsp_kind_nxt   = r_rsp_kind;
    case (r_state)
      RSP_IDLE, RSP_ACTIVE: begin
        if (w_gnt) begin
          w_state_nxt      = RSP_ACTIVE;
          w_last_owner_nxt = w_l_win ? OWN_LOADER : OWN_FETCH;
          w_rsp_owner_nxt  = w_l_win ? OWN_LOADER : OWN_FETCH;
          if (!w_legal)
            w_rsp_kind_nxt = KIND_ERR;
          else if (w_sel_we)
            w_rsp_kind_nxt = KIND_WRITE;
          else
            w_rsp_kind_nxt = KIND_READ;
        end
      end
      default: w_state_nxt = RSP_IDLE;
    endcase
  end

  // Responses are masked during reset so a pending one is never seen.
  assign w_rsp_live = !rst && (r_state == RSP_ACTIVE);
  assign f_rvalid_o = w_rsp_live && (r_rsp_owner == OWN_FETCH);
  assign l_rvalid_o = w_rsp_live && (r_rsp_owner == OWN_LOADER);
  assign f_err_o    = f_rvalid_o && (r_rsp_kind == KIND_ERR);
  assign l_err_o    = l_rvalid_o && (r_rsp_kind == KIND_ERR);
  assign f_rdata_o  = (f_rvalid_o && (r_rsp_kind == KIND_READ)) ? mem_rdata_i : 32'h0;
  assign l_rdata_o  = (l_rvalid_o && (r_rsp_kind == KIND_READ)) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a byte-organised memory model behind it.
module tb_imem_arbiter;
  localparam logic [31:0] W0   = 32'h0403_0201;
  localparam logic [31:0] W4   = 32'h0807_0605;
  localparam logic [31:0] W8   = 32'h0C0B_0A09;
  localparam logic [31:0] W1FC = 32'hCAFE_F00D;

  logic        clk, rst;
  logic        f_req_i, f_gnt_o, f_rvalid_o, f_err_o;
  logic [31:0] f_addr_i, f_rdata_o;
  logic        l_req_i, l_we_i, l_gnt_o, l_rvalid_o, l_err_o;
  logic [31:0] l_addr_i, l_wdata_i, l_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  logic [7:0]  mem [0:511];
  int          ntests = 0;
  int          nfail  = 0;

  imem_arbiter #(.MEM_SIZE(512), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
    .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o), .f_err_o(f_err_o),
    .l_req_i(l_req_i), .l_we_i(l_we_i), .l_addr_i(l_addr_i), .l_wdata_i(l_wdata_i),
    .l_gnt_o(l_gnt_o), .l_rvalid_o(l_rvalid_o), .l_rdata_o(l_rdata_o), .l_err_o(l_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: reset loads the fixed preload image; reads return next cycle.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      for (int k = 0; k < 4; k++) begin
        mem[k]       <= 8'(W0   >> (8 * k));
        mem[4 + k]   <= 8'(W4   >> (8 * k));
        mem[8 + k]   <= 8'(W8   >> (8 * k));
        mem[508 + k] <= 8'(W1FC >> (8 * k));
      end
      mem_rdata_i <= 32'h0;
    end else if (mem_en_o) begin
      if (mem_we_o) begin
        for (int k = 0; k < 4; k++)
          mem[{mem_addr_o[8:2], 2'(k)}] <= 8'(mem_wdata_o >> (8 * k));
      end else begin
        mem_rdata_i <= {mem[{mem_addr_o[8:2], 2'd3}], mem[{mem_addr_o[8:2], 2'd2}],
                        mem[{mem_addr_o[8:2], 2'd1}], mem[{mem_addr_o[8:2], 2'd0}]};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa,
                       input logic lr, input logic lw, input logic [31:0] la,
                       input logic [31:0] ld);
    @(negedge clk);
    f_req_i = fr; f_addr_i = fa;
    l_req_i = lr; l_we_i = lw; l_addr_i = la; l_wdata_i = ld;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    f_req_i = 1'b1; f_addr_i = 32'h0;
    l_req_i = 1'b1; l_we_i = 1'b0; l_addr_i = 32'h0; l_wdata_i = 32'h0;

    // Reset held with both requesting
    for (int c = 0; c < 2; c++) begin
      drive(1, 32'h0, 1, 0, 32'h0, 32'h0);
      chk("rst_f_gnt", 32'(f_gnt_o), 0);
      chk("rst_l_gnt", 32'(l_gnt_o), 0);
      chk("rst_mem_en", 32'(mem_en_o), 0);
      chk("rst_rvalid", {30'h0, f_rvalid_o, l_rvalid_o}, 0);
    end

    // Release: fetch wins first conflict, then alternation
    @(negedge clk); rst = 1'b0; #1;
    chk("c0_f_gnt", 32'(f_gnt_o), 1);
    chk("c0_l_gnt", 32'(l_gnt_o), 0);
    chk("c0_mem_en", 32'(mem_en_o), 1);
    drive(1, 32'h0, 1, 0, 32'h0, 32'h0);
    chk("c1_gnt", {30'h0, f_gnt_o, l_gnt_o}, 32'b01);
    chk("c1_f_rvalid", 32'(f_rvalid_o), 1);
    chk("c1_f_rdata", f_rdata_o, W0);
    chk("c1_f_err", 32'(f_err_o), 0);
    drive(1, 32'h0, 1, 0, 32'h0, 32'h0);
    chk("c2_gnt", {30'h0, f_gnt_o, l_gnt_o}, 32'b10);
    chk("c2_rvalid", {30'h0, f_rvalid_o, l_rvalid_o}, 32'b01);
    chk("c2_l_rdata", l_rdata_o, W0);
    drive(1, 32'h0, 1, 0, 32'h0, 32'h0);
    chk("c3_gnt", {30'h0, f_gnt_o, l_gnt_o}, 32'b01);
    chk("c3_rvalid", {30'h0, f_rvalid_o, l_rvalid_o}, 32'b10);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("c4_gnt", {30'h0, f_gnt_o, l_gnt_o}, 32'b00);
    chk("c4_rvalid", {30'h0, f_rvalid_o, l_rvalid_o}, 32'b01);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("c5_rvalid", {30'h0, f_rvalid_o, l_rvalid_o}, 32'b00);
    chk("c5_rdata_idle", f_rdata_o | l_rdata_o, 0);

    // Loader write then fetch of the same word
    drive(0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    chk("wr_l_gnt", 32'(l_gnt_o), 1);
    chk("wr_mem_we", {30'h0, mem_en_o, mem_we_o}, 32'b11);
    chk("wr_mem_addr", mem_addr_o, 32'h10);
    chk("wr_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    drive(1, 32'h10, 0, 0, 32'h0, 32'h0);
    chk("wr_ack", {29'h0, l_rvalid_o, l_err_o, f_gnt_o}, 32'b101);
    chk("wr_l_rdata", l_rdata_o, 0);
    chk("rd_mem_we", 32'(mem_we_o), 0);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("rd_f_rvalid", 32'(f_rvalid_o), 1);
    chk("rd_f_rdata", f_rdata_o, 32'hDEAD_BEEF);
    chk("mem_bytes", {mem[19], mem[18], mem[17], mem[16]}, 32'hDEAD_BEEF);
    chk("mem_byte10", 32'(mem[16]), 32'hEF);

    // Alignment / range checks
    drive(1, 32'h2, 0, 0, 32'h0, 32'h0);
    chk("mis_gnt_en", {30'h0, f_gnt_o, mem_en_o}, 32'b10);
    drive(1, 32'h1FE, 0, 0, 32'h0, 32'h0);
    chk("mis_rsp", {30'h0, f_rvalid_o, f_err_o}, 32'b11);
    chk("mis_rdata", f_rdata_o, 0);
    chk("1fe_gnt_en", {30'h0, f_gnt_o, mem_en_o}, 32'b10);
    drive(1, 32'h1FC, 0, 0, 32'h0, 32'h0);
    chk("1fe_rsp", {30'h0, f_rvalid_o, f_err_o}, 32'b11);
    chk("1fe_rdata", f_rdata_o, 0);
    chk("1fc_gnt_en", {30'h0, f_gnt_o, mem_en_o}, 32'b11);
    drive(1, 32'h200, 0, 0, 32'h0, 32'h0);
    chk("1fc_rsp", {30'h0, f_rvalid_o, f_err_o}, 32'b10);
    chk("1fc_rdata", f_rdata_o, W1FC);
    chk("200_gnt_en", {30'h0, f_gnt_o, mem_en_o}, 32'b10);
    drive(1, 32'h8000_0000, 0, 0, 32'h0, 32'h0);
    chk("200_rsp", {30'h0, f_rvalid_o, f_err_o}, 32'b11);
    chk("hi_gnt_en", {30'h0, f_gnt_o, mem_en_o}, 32'b10);

    // Back-to-back fetches
    drive(1, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("hi_rsp", {30'h0, f_rvalid_o, f_err_o}, 32'b11);
    chk("b0_gnt", 32'(f_gnt_o), 1);
    drive(1, 32'h4, 0, 0, 32'h0, 32'h0);
    chk("b1_gnt", 32'(f_gnt_o), 1);
    chk("b0_rdata", f_rdata_o, W0);
    drive(1, 32'h8, 0, 0, 32'h0, 32'h0);
    chk("b2_gnt", 32'(f_gnt_o), 1);
    chk("b1_rdata", f_rdata_o, W4);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("b2_rsp", {30'h0, f_rvalid_o, f_err_o}, 32'b10);
    chk("b2_rdata", f_rdata_o, W8);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("b3_idle", 32'(f_rvalid_o), 0);

    // Reset right after a fetch grant drops its response and restores priority
    drive(1, 32'h4, 0, 0, 32'h0, 32'h0);
    chk("rn_f_gnt", 32'(f_gnt_o), 1);
    @(negedge clk); rst = 1'b1; f_req_i = 1'b0; #1;
    chk("rn1_f_rvalid", 32'(f_rvalid_o), 0);
    chk("rn1_rdata", f_rdata_o, 0);
    @(negedge clk); rst = 1'b0;
    f_req_i = 1'b1; f_addr_i = 32'h0; l_req_i = 1'b1; l_we_i = 1'b0; l_addr_i = 32'h4; #1;
    chk("rn2_f_rvalid", 32'(f_rvalid_o), 0);
    chk("rn2_gnt", {30'h0, f_gnt_o, l_gnt_o}, 32'b10);
    drive(0, 32'h0, 1, 0, 32'h4, 32'h0);
    chk("rn3_f_rsp", 32'(f_rvalid_o), 1);
    chk("rn3_f_rdata", f_rdata_o, W0);
    chk("rn3_l_gnt", 32'(l_gnt_o), 1);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("rn4_l_rdata", l_rdata_o, W4);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port, byte-organised instruction memory between two requesters:
  - the CPU fetch stage (read-only);
  - the program loader/debug port (word read/write).
- Sits between the fetch unit / loader and the memory macro; owns the memory's enable, write-enable, address and write-data pins.
- Arbitrates round-robin, range/alignment-checks every request, and returns one response per granted request one cycle later.

Parameters:
- MEM_SIZE, 512: memory size in bytes; legal word addresses are 0 .. MEM_SIZE-4.
- ADDR_W, 32: width of all address ports.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- f_req_i  input  1  fetch request valid.
- f_addr_i  input  ADDR_W  fetch byte address.
- f_gnt_o  output  1  fetch request accepted this cycle (combinational).
- f_rvalid_o  output  1  fetch response valid (registered).
- f_rdata_o  output  32  fetch read data; little-endian {b3,b2,b1,b0}.
- f_err_o  output  1  fetch response is an error; qualified by f_rvalid_o.
- l_req_i  input  1  loader request valid.
- l_we_i  input  1  loader write (1) / read (0).
- l_addr_i  input  ADDR_W  loader byte address.
- l_wdata_i  input  32  loader write data.
- l_gnt_o  output  1  loader request accepted this cycle (combinational).
- l_rvalid_o  output  1  loader response valid (registered); also the write acknowledge.
- l_rdata_o  output  32  loader read data; 0 for writes.
- l_err_o  output  1  loader response is an error.
- mem_en_o  output  1  memory access strobe (combinational).
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  ADDR_W  memory byte address (word base).
- mem_wdata_o  output  32  memory write data.
- mem_rdata_i  input  32  memory read data, valid the cycle after mem_en_o=1, mem_we_o=0.

Behaviour:
- Reset:
  - Synchronous, active-high; no async path.
  - While rst=1: all registered outputs are 0, and all grant/mem outputs are forced to 0.
  - last_owner resets to LOADER, so fetch wins the first conflict.
- Grant (combinational, same cycle as the request):
  - Only one requester asserts req: it is granted.
  - Both assert req: grant the one that is not last_owner.
  - last_owner updates to the granted requester on every grant.
  - At most one grant per cycle. A requester that is not granted must hold req/addr/data stable until granted.
- Legality check on the granted request:
  - Illegal if addr[1:0] != 0 or addr > MEM_SIZE-4.
  - Legal: mem_en_o=1; mem_addr_o/mem_we_o/mem_wdata_o driven from the winner (mem_we_o=0 for fetch).
  - Illegal: mem_en_o=0; the request is still granted and consumed.
- Response (exactly one per grant, fixed latency 1):
  - The cycle after a grant, the winner's rvalid_o=1 for exactly one cycle.
  - rdata_o = mem_rdata_i for a legal read; 0 for a write or an error.
  - err_o=1 only for an illegal request.
  - Response registers: rsp_owner (FETCH/LOADER), rsp_kind (READ/WRITE/ERR), rsp_active.
  - FSM: RSP_IDLE -> RSP_ACTIVE on a grant. RSP_ACTIVE stays in RSP_ACTIVE on a back-to-back grant, else returns to RSP_IDLE.
  - Full throughput: one grant and one response per cycle; requesters need not wait for the response before re-requesting.
- Simultaneous events:
  - A response to one requester and a grant to the other in the same cycle is legal.
  - Each requester sees at most one rvalid per cycle.
- Reset mid-operation: a response pending at the reset edge is dropped; no rvalid is issued after reset deasserts.
- Data outputs f_rdata_o/l_rdata_o are 0 whenever the corresponding rvalid_o=0.
- Width rules:
  - The address compare uses full ADDR_W with no truncation; e.g. 0x0000_0200 is out of range for MEM_SIZE=512.
  - The memory ignores the upper address bits beyond its size.

Test Plan:
- Reset with both req=1: no grants while rst=1. First cycle after release, both request addr 0x0 -> f_gnt_o=1, l_gnt_o=0; next cycle f_rvalid_o=1 with f_rdata_o = word at 0x0.
- Both requesters held continuously at legal addresses -> grants alternate F,L,F,L over 4 cycles; each grant followed one cycle later by the matching rvalid.
- Loader write 0xDEADBEEF to 0x10, then fetch 0x10 -> l_rvalid_o=1, l_rdata_o=0, l_err_o=0; then f_rdata_o=0xDEADBEEF; memory bytes 0x10..0x13 = EF,BE,AD,DE.
- Fetch 0x0000_0002 and fetch 0x0000_01FE -> granted, mem_en_o=0, f_rvalid_o=1 with f_err_o=1, f_rdata_o=0. Fetch 0x1FC -> legal, err=0.
- Fetch back-to-back 0x0,0x4,0x8 with the loader idle -> 3 consecutive grants and 3 consecutive rvalids carrying the preloaded words in order.
- Grant fetch at cycle N, assert rst at cycle N+1 -> f_rvalid_o=0 at N+1 and N+2; last_owner=LOADER after reset, so the next conflict is won by fetch.
